// File: rtl/button_event_pkg.sv
// Shared types and default timing constants for the button event logic.
package button_event_pkg;

  // 1 s and 250 ms at 50 MHz; the debouncer's tick constants may reuse these.
  localparam int unsigned DEF_LONG_CNT = 50_000_000;
  localparam int unsigned DEF_GAP_CNT  = 12_500_000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    GAP       = 3'd3,
    PRESS2    = 3'd4
  } btn_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_edge_detect.sv
// Registered copy of a debounced level plus combinational rise/fall strobes.
// During reset the register tracks the input, so a level held through reset
// produces no edge once reset is released.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // Sample the level every cycle, including while reset is asserted.
  always_ff @(posedge clk) begin
    q <= d;
  end

  // Edges are suppressed while reset is high.
  always_comb begin
    rise = d & ~q & ~reset;
    fall = ~d & q & ~reset;
  end

endmodule

// File: rtl/button_event.sv
// Turns a debounced switch level into single-cycle press, release, click,
// double-click and long-press event pulses.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_CNT = DEF_LONG_CNT,
  parameter int unsigned GAP_CNT  = DEF_GAP_CNT
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic dclick_p,
  output logic long_p,
  output logic held
);

  localparam int unsigned CNT_W = $clog2(max_u(LONG_CNT, GAP_CNT)) + 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);

  logic             db_q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  btn_state_t       state;

  edge_detect u_edge (
    .clk  (clk),
    .reset(reset),
    .d    (db),
    .q    (db_q),
    .rise (rise),
    .fall (fall)
  );

  assign held = db_q;

  // Saturating increment so the counter can never wrap back into a threshold.
  always_comb begin
    cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  end

  // Click/long-press FSM with its counter and all registered event pulses.
  // In PRESS1/PRESS2 db_q is necessarily high, so testing db_q lets the
  // long-press threshold win over a fall arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      click_p   <= 1'b0;
      dclick_p  <= 1'b0;
      long_p    <= 1'b0;
    end else begin
      press_p   <= rise;
      release_p <= fall;
      click_p   <= 1'b0;
      dclick_p  <= 1'b0;
      long_p    <= 1'b0;
      cnt       <= cnt_inc;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) begin
            state <= PRESS1;
          end
        end
        PRESS1: begin
          if (db_q && cnt == LONG_LAST) begin
            long_p <= 1'b1;
            state  <= LONG_HELD;
            cnt    <= '0;
          end else if (fall) begin
            state <= GAP;
            cnt   <= '0;
          end
        end
        LONG_HELD: begin
          if (!db) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        GAP: begin
          if (rise) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == GAP_LAST) begin
            click_p <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
          end
        end
        PRESS2: begin
          if (db_q && cnt == LONG_LAST) begin
            click_p <= 1'b1;
            long_p  <= 1'b1;
            state   <= LONG_HELD;
            cnt     <= '0;
          end else if (fall) begin
            dclick_p <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
